// File: rtl/key_irq_scheduler_if.sv
// Interrupt handshake between key_irq_scheduler (master) and the 8-bit core (slave).
// Latency: none, wires only.
// Backpressure: the request holds until the core acknowledges; di/fetch gate new grants.
interface key_irq_scheduler_if;
  logic       irq_req;
  logic [7:0] irq_vec;
  logic       irq_ack;
  logic       di;
  logic       fetch;

  modport master (output irq_req, irq_vec, input irq_ack, di, fetch);
  modport slave  (input irq_req, irq_vec, output irq_ack, di, fetch);
endinterface

// File: rtl/key_irq_scheduler.sv
// Key debounce + auto-repeat feeding round-robin interrupt vectoring to the core.
// Latency: raw press to pending is 2 clocks + DEB_TICKS ticks + 1 clock; pending to irq_req is 1 clock.
// Backpressure: irq_req/irq_vec hold until irq_ack; pending is 1 deep and drops extra events.
module key_irq_scheduler #(
  parameter int NKEYS      = 4,
  parameter int DEB_TICKS  = 16,
  parameter int REP_DELAY  = 48,
  parameter int REP_RATE   = 12,
  parameter int VEC_BASE   = 2,
  parameter int VEC_STRIDE = 2
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               tick_i,
  input  logic [NKEYS-1:0]   key_n_i,
  key_irq_scheduler_if.master bus,
  output logic [NKEYS-1:0]   key_state_o,
  output logic [NKEYS-1:0]   pending_o
);

  localparam int IW      = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int CW      = $clog2(DEB_TICKS + 1);
  localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW      = (REP_MAX > 0) ? $clog2(REP_MAX + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  logic [NKEYS-1:0]         sync1_q, sync2_q;
  logic [NKEYS-1:0]         key_q, key_d;
  logic [NKEYS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NKEYS-1:0][RW-1:0] rep_q, rep_d;
  logic [NKEYS-1:0]         ev_q, ev_d;
  logic [NKEYS-1:0]         pending_q, pending_d;
  logic [NKEYS-1:0]         clr;
  state_t                   state_q;
  logic [IW-1:0]            g_q, rr_q, gnt_idx;
  logic                     gnt_vld;
  logic                     irq_req_q;
  logic [7:0]               irq_vec_q;

  function automatic logic [7:0] vec_of(input logic [IW-1:0] g);
    int v;
    v = VEC_BASE + VEC_STRIDE * int'(g);
    return v[7:0];
  endfunction

  always_comb begin
    key_d = key_q;
    cnt_d = cnt_q;
    rep_d = rep_q;
    ev_d  = '0;
    if (tick_i) begin
      for (int i = 0; i < NKEYS; i++) begin
        if (~sync2_q[i] != key_q[i]) begin
          if (cnt_q[i] == CW'(DEB_TICKS - 1)) begin
            key_d[i] = ~key_q[i];
            cnt_d[i] = '0;
            if (!key_q[i]) begin
              ev_d[i]  = 1'b1;
              rep_d[i] = RW'(REP_DELAY);
            end else begin
              rep_d[i] = '0;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
        // Repeat timer only runs while the key stays held through this tick.
        if (key_q[i] && key_d[i] && rep_q[i] != '0) begin
          if (rep_q[i] == RW'(1)) begin
            ev_d[i]  = 1'b1;
            rep_d[i] = RW'(REP_RATE);
          end else begin
            rep_d[i] = rep_q[i] - 1'b1;
          end
        end
      end
    end
  end

  // A new event in the same clock as the ack keeps the source pending.
  always_comb begin
    clr = '0;
    if (state_q == S_REQ && bus.irq_ack) clr[g_q] = 1'b1;
    pending_d = (pending_q & ~clr) | ev_q;
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NKEYS; k++) begin
      if (!gnt_vld && pending_q[(int'(rr_q) + k) % NKEYS]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'((int'(rr_q) + k) % NKEYS);
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      key_q     <= '0;
      cnt_q     <= '0;
      rep_q     <= '0;
      ev_q      <= '0;
      pending_q <= '0;
    end else begin
      sync1_q   <= key_n_i;
      sync2_q   <= sync1_q;
      key_q     <= key_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      ev_q      <= ev_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      g_q       <= '0;
      rr_q      <= '0;
      irq_req_q <= 1'b0;
      irq_vec_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_vld && !bus.di && bus.fetch) begin
            g_q       <= gnt_idx;
            irq_vec_q <= vec_of(gnt_idx);
            irq_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.irq_ack) begin
            irq_req_q <= 1'b0;
            rr_q      <= IW'((int'(g_q) + 1) % NKEYS);
            state_q   <= S_GAP;
          end
        end
        // One dead clock so the core runs a handler instruction before the next grant.
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.irq_req  = irq_req_q;
  assign bus.irq_vec  = irq_vec_q;
  assign key_state_o  = key_q;
  assign pending_o    = pending_q;

endmodule

// File: tb/tb_key_irq_scheduler.sv
// Bench for key_irq_scheduler with DEB_TICKS=4, REP_DELAY=8, REP_RATE=3, tick mostly every clock.
// Expected vectors are queued as keys are driven and popped on each rising irq_req.
module tb_key_irq_scheduler;
  localparam int NK = 4;

  logic          clock = 1'b0;
  logic          rst   = 1'b0;
  logic          tick  = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_state, pending;

  key_irq_scheduler_if bus();

  key_irq_scheduler #(
    .NKEYS(4), .DEB_TICKS(4), .REP_DELAY(8), .REP_RATE(3), .VEC_BASE(2), .VEC_STRIDE(2)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .tick_i     (tick),
    .key_n_i    (key_n),
    .bus        (bus),
    .key_state_o(key_state),
    .pending_o  (pending)
  );

  always #5 clock = ~clock;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  int         gcyc[$];
  bit         auto_ack = 1'b0;
  bit         spur_ack = 1'b0;
  logic       prev_req = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [NK-1:0] m, input int hold);
    key_n = key_n & ~m;
    tk(hold);
    key_n = key_n | m;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 120; i++) begin
      if (exp_q.size() == 0 && !bus.irq_req) break;
      tk(1);
    end
    chk(tag, 32'(exp_q.size()), 0);
    tk(3);
  endtask

  // Scoreboard: every new request must match the oldest queued vector.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.irq_req && !prev_req) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("grant_vec", 32'(bus.irq_vec), 32'(exp_q.pop_front()));
        gcyc.push_back(cyc);
      end
      prev_req = bus.irq_req;
    end
  end

  initial begin
    bus.irq_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (auto_ack) begin
        if (bus.irq_ack) bus.irq_ack = 1'b0;
        else if (bus.irq_req) bus.irq_ack = 1'b1;
      end else begin
        bus.irq_ack = spur_ack;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int c0;
    bus.di    = 1'b0;
    bus.fetch = 1'b1;
    tk(3);
    chk("rst_req", 32'(bus.irq_req), 0);
    chk("rst_vec", 32'(bus.irq_vec), 0);
    chk("rst_keys", 32'(key_state), 0);
    chk("rst_pend", 32'(pending), 0);
    rst = 1'b1;
    tk(2);

    // Keys 0 and 3 on the same tick, rr=0: vec 2, then vec 8 after ack + gap.
    auto_ack = 1'b1;
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd8);
    gcyc.delete();
    press(4'b1001, 6);
    wait_drain("t4_drain");
    chk("t4_ngrant", 32'(gcyc.size()), 2);
    if (gcyc.size() >= 2) chk("t4_spacing", 32'(gcyc[1] - gcyc[0]), 3);

    // Single press on key 0 with a manually held request.
    auto_ack = 1'b0;
    exp_q.push_back(8'd2);
    c0 = cyc;
    key_n[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tk(1);
      if (pending[0]) break;
    end
    chk("t1_pend_lat", 32'(cyc - c0), 7);
    key_n[0] = 1'b1;
    tk(1);
    chk("t1_req", 32'(bus.irq_req), 1);
    bus.di = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tk(1);
      chk("t1_hold_req", 32'(bus.irq_req), 1);
      chk("t1_hold_vec", 32'(bus.irq_vec), 2);
    end
    bus.di   = 1'b0;
    auto_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tk(1);
      if (!bus.irq_req) break;
    end
    chk("t1_req_drop", 32'(bus.irq_req), 0);
    chk("t1_pend_clr", 32'(pending[0]), 0);
    tk(10);
    chk("t1_key_rel", 32'(key_state[0]), 0);

    // Too-short press and a press while tick is held low: nothing happens.
    press(4'b0100, 3);
    tk(15);
    chk("t2_keys", 32'(key_state), 0);
    chk("t2_pend", 32'(pending), 0);
    chk("t2_req", 32'(bus.irq_req), 0);
    tick = 1'b0;
    key_n[2] = 1'b0;
    tk(12);
    chk("t2_tick0_keys", 32'(key_state), 0);
    key_n[2] = 1'b1;
    tk(4);
    tick = 1'b1;
    tk(8);
    chk("t2_tick0_pend", 32'(pending), 0);

    // Key 1 held 20 clocks: press grant, repeat after 8, then every 3.
    repeat (5) exp_q.push_back(8'd4);
    gcyc.delete();
    c0 = cyc;
    press(4'b0010, 20);
    wait_drain("t3_drain");
    chk("t3_ngrant", 32'(gcyc.size()), 5);
    if (gcyc.size() == 5) begin
      chk("t3_first", 32'(gcyc[0] - c0), 8);
      for (int k = 1; k < 5; k++) chk("t3_interval", 32'(gcyc[k] - gcyc[k-1]), (k == 1) ? 8 : 3);
    end

    // rr now 2: keys 0 and 3 together serve 3 first.
    exp_q.push_back(8'd8);
    exp_q.push_back(8'd2);
    press(4'b1001, 6);
    wait_drain("t4b_drain");

    // di and fetch gating; stray ack in IDLE is ignored; released key stays pending.
    auto_ack = 1'b0;
    bus.di   = 1'b1;
    press(4'b0010, 6);
    tk(12);
    chk("t5_pend_di", 32'(pending[1]), 1);
    chk("t5_req_di", 32'(bus.irq_req), 0);
    chk("t5_key_rel", 32'(key_state[1]), 0);
    spur_ack = 1'b1;
    tk(1);
    spur_ack = 1'b0;
    tk(2);
    chk("t5_stray_ack", 32'(pending[1]), 1);
    bus.fetch = 1'b0;
    bus.di    = 1'b0;
    tk(4);
    chk("t5_req_nofetch", 32'(bus.irq_req), 0);
    auto_ack = 1'b1;
    exp_q.push_back(8'd4);
    bus.fetch = 1'b1;
    tk(1);
    chk("t5_req", 32'(bus.irq_req), 1);
    wait_drain("t5_drain");

    // Reset while requesting, key 2 held through it.
    auto_ack = 1'b0;
    exp_q.push_back(8'd6);
    key_n[2] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tk(1);
      if (bus.irq_req) break;
    end
    chk("t6_req", 32'(bus.irq_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_req", 32'(bus.irq_req), 0);
    chk("t6_rst_pend", 32'(pending), 0);
    chk("t6_rst_keys", 32'(key_state), 0);
    tk(1);
    rst = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 30; i++) begin
      tk(1);
      if (key_state[2]) break;
    end
    chk("t6_redebounce", 32'(cyc - c0), 6);
    key_n[2] = 1'b1;
    exp_q.push_back(8'd6);
    auto_ack = 1'b1;
    wait_drain("t6_drain");

    chk("sb_final", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
